// File: rtl/wired_rr_arbiter.sv
// Round-robin arbiter that merges N_REQ valid/ready requesters onto one registered output channel.
// Bursts hold the grant until their last beat; a main+spill stage isolates outport_ready from inport_ready.
module wired_rr_arbiter #(
  parameter int  N_REQ      = 4,
  parameter int  DATA_WIDTH = 32,
  parameter type T          = logic [DATA_WIDTH-1:0],
  parameter int  ID_W       = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] inport_valid,
  output logic [N_REQ-1:0] inport_ready,
  input  T                 inport_payload [N_REQ],
  input  logic [N_REQ-1:0] inport_last,
  output logic             outport_valid,
  input  logic             outport_ready,
  output T                 outport_payload,
  output logic [ID_W-1:0]  outport_id,
  output logic             outport_last,
  output logic             dbg_locked,
  output logic [ID_W-1:0]  dbg_ptr
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge; valid never waits on ready.

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            main_valid_q, main_valid_d;
  T                main_payload_q, main_payload_d;
  logic [ID_W-1:0] main_id_q, main_id_d;
  logic            main_last_q, main_last_d;

  logic            spill_valid_q, spill_valid_d;
  T                spill_payload_q, spill_payload_d;
  logic [ID_W-1:0] spill_id_q, spill_id_d;
  logic            spill_last_q, spill_last_d;

  logic            acc_rdy_q;

  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] scan_idx;
  int              scan_sum;
  logic            grant_any;
  logic [N_REQ-1:0] grant_vec;
  logic            accept;
  logic            beat_last;
  T                beat_payload;
  logic [ID_W-1:0] next_ptr;
  logic            fire;

  // Winner selection: locked burst owner, or first valid requester starting at ptr.
  always_comb begin
    winner    = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    scan_sum  = 0;
    if (state_q == LOCKED) begin
      winner    = lock_id_q;
      grant_any = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_sum = int'(ptr_q) + k;
        if (scan_sum >= N_REQ) scan_sum = scan_sum - N_REQ;
        scan_idx = ID_W'(scan_sum);
        if (!grant_any && inport_valid[scan_idx]) begin
          winner    = scan_idx;
          grant_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (grant_any) grant_vec[winner] = 1'b1;
  end

  assign inport_ready = grant_vec & {N_REQ{acc_rdy_q}};
  assign accept       = grant_any & acc_rdy_q & inport_valid[winner];
  assign beat_last    = inport_last[winner];
  assign beat_payload = inport_payload[winner];
  assign next_ptr     = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
  assign fire         = main_valid_q & outport_ready;

  // Burst lock FSM and round-robin pointer.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    ptr_d     = ptr_q;
    if (accept) begin
      if (beat_last) begin
        state_d = IDLE;
        ptr_d   = next_ptr;
      end else begin
        state_d   = LOCKED;
        lock_id_d = winner;
      end
    end
  end

  // Main+spill output stage; the spill slot absorbs the beat accepted while main is stalled.
  always_comb begin
    main_valid_d    = main_valid_q;
    main_payload_d  = main_payload_q;
    main_id_d       = main_id_q;
    main_last_d     = main_last_q;
    spill_valid_d   = spill_valid_q;
    spill_payload_d = spill_payload_q;
    spill_id_d      = spill_id_q;
    spill_last_d    = spill_last_q;
    if (spill_valid_q) begin
      if (fire) begin
        main_payload_d = spill_payload_q;
        main_id_d      = spill_id_q;
        main_last_d    = spill_last_q;
        spill_valid_d  = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || fire) begin
        main_valid_d   = 1'b1;
        main_payload_d = beat_payload;
        main_id_d      = winner;
        main_last_d    = beat_last;
      end else begin
        spill_valid_d   = 1'b1;
        spill_payload_d = beat_payload;
        spill_id_d      = winner;
        spill_last_d    = beat_last;
      end
    end else if (fire) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      ptr_q     <= ptr_d;
    end
  end

  // acc_rdy is held low in reset so no requester sees ready while the block is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q    <= 1'b0;
      main_payload_q  <= '0;
      main_id_q       <= '0;
      main_last_q     <= 1'b0;
      spill_valid_q   <= 1'b0;
      spill_payload_q <= '0;
      spill_id_q      <= '0;
      spill_last_q    <= 1'b0;
      acc_rdy_q       <= 1'b0;
    end else begin
      main_valid_q    <= main_valid_d;
      main_payload_q  <= main_payload_d;
      main_id_q       <= main_id_d;
      main_last_q     <= main_last_d;
      spill_valid_q   <= spill_valid_d;
      spill_payload_q <= spill_payload_d;
      spill_id_q      <= spill_id_d;
      spill_last_q    <= spill_last_d;
      acc_rdy_q       <= !spill_valid_d;
    end
  end

  assign outport_valid   = main_valid_q;
  assign outport_payload = main_payload_q;
  assign outport_id      = main_id_q;
  assign outport_last    = main_last_q;
  assign dbg_locked      = (state_q == LOCKED);
  assign dbg_ptr         = ptr_q;

endmodule
